controller_rom_loader: RTL and testbench

//  Upstream feeder for the controller ROM/RAM (32-bit word, 4-lane byte-enable, 1-cycle read latency).
//  It packs a byte download stream into big-endian 32-bit words and writes them into the ROM port.
//  The controller CPU owns the same port whenever no download is active.
//  The CPU is held off with cpu_hold while a download runs.

---
 rtl/controller_rom_loader.sv | 188 ++++++++++++++++++
 tb/tb_controller_rom_loader.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/controller_rom_loader.sv
// Packs a big-endian byte download stream into 32-bit words for the controller ROM port,
// and passes the CPU straight through to the same port whenever no download is running.
module controller_rom_loader #(
  parameter int ADDR_WIDTH = 15
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  dl_start,
  input  logic [ADDR_WIDTH-1:0] dl_base,
  input  logic                  dl_valid,
  input  logic [7:0]            dl_data,
  output logic                  dl_ready,
  input  logic                  dl_end,
  output logic                  busy,
  output logic                  done,
  output logic                  cpu_hold,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [3:0]            cpu_bytesel,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [31:0]           cpu_d,
  output logic [31:0]           cpu_q,
  output logic                  cpu_ack,
  output logic                  rom_we,
  output logic [3:0]            rom_bytesel,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  output logic [31:0]           rom_d,
  input  logic [31:0]           rom_q
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COLLECT = 3'd1,
    ST_WRITE   = 3'd2,
    ST_FLUSH   = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  state_t                state_r, state_s;
  logic [1:0]            cnt_r, cnt_s;
  logic [ADDR_WIDTH-1:0] addr_r, addr_s;
  logic [31:0]           data_r, data_s;
  logic [3:0]            sel_r, sel_s;
  logic                  end_pend_r, end_pend_s;
  logic                  cpu_ack_r;

  // Byte-lane mask covering the first n bytes of a word (lane 0 = d[31:24]).
  function automatic logic [3:0] lane_mask(input logic [2:0] n);
    logic [3:0] m;
    case (n)
      3'd1:    m = 4'b0001;
      3'd2:    m = 4'b0011;
      3'd3:    m = 4'b0111;
      3'd4:    m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= ST_IDLE;
      cnt_r      <= 2'd0;
      addr_r     <= '0;
      data_r     <= 32'd0;
      sel_r      <= 4'b0000;
      end_pend_r <= 1'b0;
      cpu_ack_r  <= 1'b0;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      addr_r     <= addr_s;
      data_r     <= data_s;
      sel_r      <= sel_s;
      end_pend_r <= end_pend_s;
      cpu_ack_r  <= (state_r == ST_IDLE) && cpu_req;
    end
  end

  // Next-state logic: byte packing, end-of-stream handling and address advance.
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    addr_s     = addr_r;
    data_s     = data_r;
    sel_s      = sel_r;
    end_pend_s = end_pend_r;
    case (state_r)
      ST_IDLE: begin
        if (dl_start) begin
          addr_s     = dl_base;
          cnt_s      = 2'd0;
          data_s     = 32'd0;
          sel_s      = 4'b0000;
          end_pend_s = 1'b0;
          state_s    = ST_COLLECT;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_COLLECT: begin
        if (dl_valid) begin
          case (cnt_r)
            2'd0:    data_s[31:24] = dl_data;
            2'd1:    data_s[23:16] = dl_data;
            2'd2:    data_s[15:8]  = dl_data;
            default: data_s[7:0]   = dl_data;
          endcase
          if (cnt_r == 2'd3) begin
            // A same-cycle dl_end still gets its full-word write before finishing.
            cnt_s      = 2'd0;
            end_pend_s = dl_end;
            state_s    = ST_WRITE;
          end else if (dl_end) begin
            cnt_s   = cnt_r + 2'd1;
            sel_s   = lane_mask({1'b0, cnt_r} + 3'd1);
            state_s = ST_FLUSH;
          end else begin
            cnt_s = cnt_r + 2'd1;
          end
        end else if (dl_end) begin
          if (cnt_r == 2'd0) begin
            state_s = ST_DONE;
          end else begin
            sel_s   = lane_mask({1'b0, cnt_r});
            state_s = ST_FLUSH;
          end
        end else begin
          state_s = ST_COLLECT;
        end
      end
      ST_WRITE: begin
        addr_s = addr_r + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
        cnt_s  = 2'd0;
        data_s = 32'd0;
        if (end_pend_r) begin
          end_pend_s = 1'b0;
          state_s    = ST_DONE;
        end else begin
          state_s = ST_COLLECT;
        end
      end
      ST_FLUSH: begin
        cnt_s   = 2'd0;
        data_s  = 32'd0;
        state_s = ST_DONE;
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // ROM port mux: CPU pass-through when idle, loader registers otherwise.
  always_comb begin
    rom_we      = 1'b0;
    rom_bytesel = 4'b0000;
    rom_addr    = addr_r;
    rom_d       = data_r;
    if (state_r == ST_IDLE) begin
      rom_we      = cpu_req & cpu_we;
      rom_bytesel = cpu_bytesel;
      rom_addr    = cpu_addr;
      rom_d       = cpu_d;
    end else if (state_r == ST_WRITE) begin
      rom_we      = 1'b1;
      rom_bytesel = 4'b1111;
    end else if (state_r == ST_FLUSH) begin
      rom_we      = 1'b1;
      rom_bytesel = sel_r;
    end else begin
      rom_we      = 1'b0;
      rom_bytesel = 4'b0000;
    end
  end

  assign dl_ready = (state_r == ST_COLLECT);
  assign busy     = (state_r != ST_IDLE);
  assign cpu_hold = (state_r != ST_IDLE);
  assign done     = (state_r == ST_DONE);
  assign cpu_ack  = cpu_ack_r;
  assign cpu_q    = rom_q;

endmodule

// File: tb/tb_controller_rom_loader.sv
// Directed and randomized downloads checked against a word-level model of the expected ROM writes
// and contents; the bench also models the ROM itself (byte-lane writes, 1-cycle registered read).
module tb_controller_rom_loader;
  localparam int AW = 15;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          dl_start, dl_valid, dl_end;
  logic [AW-1:0] dl_base;
  logic [7:0]    dl_data;
  logic          dl_ready, busy, done, cpu_hold;
  logic          cpu_req, cpu_we, cpu_ack;
  logic [3:0]    cpu_bytesel;
  logic [AW-1:0] cpu_addr;
  logic [31:0]   cpu_d, cpu_q;
  logic          rom_we;
  logic [3:0]    rom_bytesel;
  logic [AW-1:0] rom_addr;
  logic [31:0]   rom_d;
  logic [31:0]   rom_q = 32'd0;

  always #5 clk = ~clk;

  controller_rom_loader #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset_n(reset_n),
    .dl_start(dl_start), .dl_base(dl_base), .dl_valid(dl_valid), .dl_data(dl_data),
    .dl_ready(dl_ready), .dl_end(dl_end), .busy(busy), .done(done), .cpu_hold(cpu_hold),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_bytesel(cpu_bytesel), .cpu_addr(cpu_addr),
    .cpu_d(cpu_d), .cpu_q(cpu_q), .cpu_ack(cpu_ack),
    .rom_we(rom_we), .rom_bytesel(rom_bytesel), .rom_addr(rom_addr), .rom_d(rom_d), .rom_q(rom_q)
  );

  logic [31:0] mem     [0:(1<<AW)-1];
  logic [31:0] ref_mem [0:(1<<AW)-1];

  typedef struct packed {
    logic [AW-1:0] a;
    logic [31:0]   d;
    logic [3:0]    s;
  } wr_t;

  wr_t         obs_q[$];
  int          done_cnt = 0;
  logic [7:0]  stim_q[$];
  int          vec_cnt = 0;
  int          mis_cnt = 0;

  // Lane j of a word is bits [31-8j -: 8]; selected lanes take the new data.
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] sel);
    logic [31:0] r;
    r = old;
    for (int j = 0; j < 4; j++)
      if (sel[j]) r[31-8*j -: 8] = nw[31-8*j -: 8];
    return r;
  endfunction

  // ROM model: registered read of the old word, byte-lane write.
  always @(posedge clk) begin
    rom_q <= mem[rom_addr];
    if (rom_we) mem[rom_addr] <= merge(mem[rom_addr], rom_d, rom_bytesel);
  end

  // Write/done monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (rom_we && busy) obs_q.push_back('{a: rom_addr, d: rom_d, s: rom_bytesel});
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      mis_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = dl_ready;
    end
    check(tag, seen, 1'b1);
  endtask

  task automatic wait_idle(input string tag);
    logic idle;
    idle = 1'b0;
    for (int i = 0; i < 50 && !idle; i++) begin
      @(negedge clk);
      idle = !busy;
    end
    check(tag, idle, 1'b1);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic with_end, input logic completes);
    repeat ($urandom_range(0, 2)) tick();
    wait_ready("byte_ready");
    dl_valid = 1'b1;
    dl_data  = b;
    dl_end   = with_end;
    tick();
    dl_valid = 1'b0;
    dl_end   = 1'b0;
    if (completes) begin
      @(negedge clk);
      check("word_latency_rom_we", rom_we, 1'b1);
    end
  endtask

  task automatic cpu_read(input logic [AW-1:0] a);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = a;
    tick();
    cpu_req = 1'b0;
    @(negedge clk);
    check("cpu_read_ack", cpu_ack, 1'b1);
    check("cpu_read_q", cpu_q, ref_mem[a]);
  endtask

  // Stream stim_q as one download; expected writes are derived from the byte list alone.
  task automatic download(input logic [AW-1:0] base, input logic end_with_last);
    wr_t exp_q[$];
    int  n, nw, d0, cnt;
    logic [31:0] w;
    n = stim_q.size();
    obs_q.delete();
    d0 = done_cnt;
    dl_start = 1'b1; dl_base = base;
    tick();
    dl_start = 1'b0;
    for (int i = 0; i < n; i++)
      send_byte(stim_q[i], end_with_last && (i == n-1), (i % 4) == 3);
    if (!(end_with_last && n > 0)) begin
      wait_ready("end_ready");
      dl_end = 1'b1;
      tick();
      dl_end = 1'b0;
    end
    wait_idle("dl_finish");
    nw = (n + 3) / 4;
    for (int k = 0; k < nw; k++) begin
      cnt = (n - 4*k >= 4) ? 4 : n - 4*k;
      w = 32'd0;
      for (int j = 0; j < cnt; j++) w[31-8*j -: 8] = stim_q[4*k+j];
      exp_q.push_back('{a: AW'(int'(base) + k), d: w, s: 4'((1 << cnt) - 1)});
      ref_mem[AW'(int'(base) + k)] = merge(ref_mem[AW'(int'(base) + k)], w, 4'((1 << cnt) - 1));
    end
    check("write_count", obs_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
      check("write_addr", obs_q[k].a, exp_q[k].a);
      check("write_data", obs_q[k].d, exp_q[k].d);
      check("write_bytesel", obs_q[k].s, exp_q[k].s);
    end
    check("done_pulses", done_cnt - d0, 1);
  endtask

  initial begin
    logic [AW-1:0] b;
    int d0;
    reset_n = 1'b0;
    dl_start = 1'b0; dl_valid = 1'b0; dl_end = 1'b0; dl_base = '0; dl_data = 8'd0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_bytesel = 4'b0000; cpu_addr = '0; cpu_d = 32'd0;
    for (int i = 0; i < (1 << AW); i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    #12;
    check("rst_dl_ready", dl_ready, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_cpu_hold", cpu_hold, 1'b0);
    check("rst_cpu_ack", cpu_ack, 1'b0);
    check("rst_rom_we", rom_we, 1'b0);
    tick();
    reset_n = 1'b1;
    tick();

    // CPU write in IDLE: combinational pass-through, ack one cycle later.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_bytesel = 4'b0010; cpu_addr = 15'd5; cpu_d = $urandom;
    @(negedge clk);
    check("cpu_wr_rom_we", rom_we, 1'b1);
    check("cpu_wr_rom_addr", rom_addr, 15'd5);
    check("cpu_wr_rom_bytesel", rom_bytesel, 4'b0010);
    check("cpu_wr_rom_d", rom_d, cpu_d);
    ref_mem[5] = merge(ref_mem[5], cpu_d, 4'b0010);
    tick();
    cpu_req = 1'b0; cpu_we = 1'b0;
    @(negedge clk);
    check("cpu_wr_ack", cpu_ack, 1'b1);
    cpu_read(15'd5);

    // dl_end/dl_valid while idle are ignored.
    d0 = done_cnt;
    dl_end = 1'b1; dl_valid = 1'b1;
    tick();
    dl_end = 1'b0; dl_valid = 1'b0;
    @(negedge clk);
    check("idle_end_busy", busy, 1'b0);
    check("idle_end_done", done_cnt - d0, 0);

    // Two full words.
    stim_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    download(15'h0010, 1'b0);
    check("t1_word0", ref_mem[15'h0010], 32'h11223344);
    cpu_read(15'h0010);
    cpu_read(15'h0011);

    // Partial word flush.
    b = AW'($urandom);
    stim_q = '{8'hAA, 8'hBB, 8'hCC};
    download(b, 1'b0);
    cpu_read(b);

    // Address wrap.
    stim_q.delete();
    for (int i = 0; i < 8; i++) stim_q.push_back(8'($urandom));
    download(15'h7FFF, 1'b0);
    cpu_read(15'h7FFF);
    cpu_read(15'h0000);

    // dl_end together with the 4th byte, then an empty download.
    stim_q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    download(AW'($urandom), 1'b1);
    stim_q.delete();
    download(AW'($urandom), 1'b0);

    // CPU request during a download: no write, no ack.
    obs_q.delete();
    d0 = done_cnt;
    dl_start = 1'b1; dl_base = AW'($urandom);
    tick();
    dl_start = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_bytesel = 4'b0010; cpu_addr = 15'd5; cpu_d = $urandom;
    @(negedge clk);
    check("busy_cpu_rom_we", rom_we, 1'b0);
    check("busy_cpu_hold", cpu_hold, 1'b1);
    tick();
    cpu_req = 1'b0; cpu_we = 1'b0;
    @(negedge clk);
    check("busy_cpu_ack", cpu_ack, 1'b0);
    dl_end = 1'b1;
    tick();
    dl_end = 1'b0;
    wait_idle("busy_cpu_finish");
    check("busy_cpu_writes", obs_q.size(), 0);
    check("busy_cpu_done", done_cnt - d0, 1);
    cpu_read(15'd5);

    // Reset mid-download after two bytes.
    obs_q.delete();
    d0 = done_cnt;
    dl_start = 1'b1; dl_base = AW'($urandom);
    tick();
    dl_start = 1'b0;
    send_byte(8'h12, 1'b0, 1'b0);
    send_byte(8'h34, 1'b0, 1'b0);
    reset_n = 1'b0;
    #2;
    check("midrst_busy", busy, 1'b0);
    check("midrst_cpu_hold", cpu_hold, 1'b0);
    check("midrst_dl_ready", dl_ready, 1'b0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    check("midrst_writes", obs_q.size(), 0);
    check("midrst_done", done_cnt - d0, 0);
    stim_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    download(15'h0123, 1'b0);
    check("midrst_new_word", ref_mem[15'h0123], 32'h01020304);
    cpu_read(15'h0123);
    cpu_read(15'h0124);

    // Randomized downloads.
    for (int t = 0; t < 8; t++) begin
      b = AW'($urandom);
      stim_q.delete();
      repeat ($urandom_range(0, 11)) stim_q.push_back(8'($urandom));
      download(b, 1'($urandom));
      cpu_read(b);
      cpu_read(AW'(int'(b) + 1));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, mis_cnt);
    $finish;
  end
endmodule
